// File: rtl/mem_scan_pkg.sv
// Shared MMIO map and engine state type for the memory responder with min-search engine.
package mem_scan_pkg;

  localparam logic [15:0] MmioPage   = 16'hFFFF;
  localparam logic [31:0] CtrlAddr   = 32'hFFFF_0000;
  localparam logic [31:0] MinValAddr = 32'hFFFF_0004;
  localparam logic [31:0] MinIdxAddr = 32'hFFFF_0008;
  localparam logic [31:0] StatusAddr = 32'hFFFF_000C;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } scan_state_t;

  // True when a byte address hits the given MMIO register (byte offset bits ignored).
  function automatic logic mmio_hit(input logic [31:0] adr, input logic [31:0] reg_addr);
    return (adr[31:2] == reg_addr[31:2]);
  endfunction

endpackage

// File: rtl/min_scan_fsm.sv
// Minimum-search engine: walks ScanCount words from ScanBase, one per cycle, tracking the
// signed minimum and the lowest index at which it occurs.
module min_scan_fsm
  import mem_scan_pkg::*;
#(
  parameter int unsigned AddrW     = 10,
  parameter logic [31:0] ScanBase  = 32'd1000,
  parameter int unsigned ScanCount = 20
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [31:0]      rdata_i,
  output logic [AddrW-1:0] raddr_o,
  output logic [31:0]      min_value_o,
  output logic [31:0]      min_index_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned     IdxW     = (ScanCount > 1) ? $clog2(ScanCount) : 1;
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(ScanCount - 1);
  localparam logic [31:0]     BaseWord = ScanBase >> 2;

  scan_state_t     state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [31:0]     min_val_q, min_val_d;
  logic [IdxW-1:0] min_idx_q, min_idx_d;
  logic            done_q, done_d;

  // Word address wraps modulo the RAM depth, matching processor-side aliasing.
  assign raddr_o = BaseWord[AddrW-1:0] + AddrW'(idx_q);

  // Next-state: start from IDLE/DONE, compare-and-update each cycle while scanning.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    min_val_d = min_val_q;
    min_idx_d = min_idx_q;
    done_d    = done_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = SCAN;
          idx_d   = '0;
          done_d  = 1'b0;
        end
      end
      SCAN: begin
        // Strict less-than keeps the earliest index on ties.
        if ((idx_q == '0) || ($signed(rdata_i) < $signed(min_val_q))) begin
          min_val_d = rdata_i;
          min_idx_d = idx_q;
        end
        if (idx_q == LastIdx) begin
          state_d = DONE;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Engine state registers; reset clears results as well as control.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      min_val_q <= '0;
      min_idx_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      min_val_q <= min_val_d;
      min_idx_q <= min_idx_d;
      done_q    <= done_d;
    end
  end

  assign min_value_o = min_val_q;
  assign min_index_o = 32'(min_idx_q);
  assign busy_o      = (state_q == SCAN);
  assign done_o      = done_q;

endmodule

// File: rtl/mem_scan_responder.sv
// Unified instruction/data memory on the responder side of the MIPS memory port, with an
// MMIO-controlled minimum-search engine reading the RAM through a second read port.
module mem_scan_responder
  import mem_scan_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] SCAN_BASE   = 32'd1000,
  parameter int unsigned SCAN_COUNT  = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_data_adr,
  input  logic [31:0] mem_data_in,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] mem_out,
  output logic [31:0] min_value,
  output logic [31:0] min_index,
  output logic        scan_busy,
  output logic        scan_done
);

  localparam int unsigned AddrW = $clog2(DEPTH_WORDS);

  logic [31:0]      mem_q [DEPTH_WORDS];
  logic [AddrW-1:0] ram_addr;
  logic [AddrW-1:0] scan_raddr;
  logic [31:0]      scan_rdata;
  logic             is_mmio;
  logic             ram_we;
  logic             start;
  logic             unused_adr_bits;

  assign unused_adr_bits = ^inst_data_adr[1:0];

  assign is_mmio  = (inst_data_adr[31:16] == MmioPage);
  assign ram_addr = inst_data_adr[AddrW+1:2];
  assign ram_we   = mem_write & ~is_mmio;
  assign start    = mem_write & mmio_hit(inst_data_adr, CtrlAddr) & mem_data_in[0];

  // RAM write port; contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem_q[ram_addr] <= mem_data_in;
    end
  end

  assign scan_rdata = mem_q[scan_raddr];

  // Processor read mux: RAM word or MMIO register, zero when not reading.
  always_comb begin
    mem_out = '0;
    if (mem_read) begin
      if (!is_mmio) begin
        mem_out = mem_q[ram_addr];
      end else if (mmio_hit(inst_data_adr, MinValAddr)) begin
        mem_out = min_value;
      end else if (mmio_hit(inst_data_adr, MinIdxAddr)) begin
        mem_out = min_index;
      end else if (mmio_hit(inst_data_adr, StatusAddr)) begin
        mem_out = {30'b0, scan_busy, scan_done};
      end
    end
  end

  min_scan_fsm #(
    .AddrW    (AddrW),
    .ScanBase (SCAN_BASE),
    .ScanCount(SCAN_COUNT)
  ) u_min_scan_fsm (
    .clk_i      (clk),
    .rst_ni     (rst),
    .start_i    (start),
    .rdata_i    (scan_rdata),
    .raddr_o    (scan_raddr),
    .min_value_o(min_value),
    .min_index_o(min_index),
    .busy_o     (scan_busy),
    .done_o     (scan_done)
  );

endmodule
